mem_stage: RTL and testbench

- Pipeline stage directly downstream of execute; consumes execute's ALU result (address or pass-through value), store data and writeback controls.
- Runs a request/grant/response handshake with a multi-cycle data memory, stalls upstream while an access is outstanding, and registers results for writeback.
- Also detects unaligned word accesses and memory timeouts, and latches the halt condition.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_timeout_ctr.sv | 40 ++++
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RESP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // A word access must sit on an even address.
    function automatic logic is_unaligned(input logic mem_op, input logic addr_lsb);
        return mem_op & addr_lsb;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles an access has been outstanding; o_expired is high during the
// last permitted cycle (count == TIMEOUT-1) and beyond.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_expired;

    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign o_expired = r_expired;

    // Count register with the expiry flag computed one cycle ahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_expired <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_expired <= (LIMIT == {CNT_W{1'b0}});
        end else if (i_en) begin
            r_cnt     <= w_cnt_inc;
            r_expired <= (w_cnt_inc >= LIMIT);
        end else begin
            r_cnt     <= r_cnt;
            r_expired <= r_expired;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: req/gnt/resp handshake to data memory, stalls execute
// while an access is outstanding, flags unaligned/timeout errors and halts.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_aluOut,
    input  logic [DATA_W-1:0]     in_writeData,
    input  logic                  in_memRead,
    input  logic                  in_memWrite,
    input  logic                  in_halt,
    input  logic                  in_regWrite,
    input  logic [REG_ADDR_W-1:0] in_writeReg,
    input  logic                  in_memToReg,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_readData,
    output logic [DATA_W-1:0]     out_aluOut,
    output logic                  out_regWrite,
    output logic [REG_ADDR_W-1:0] out_writeReg,
    output logic                  out_memToReg,
    output logic                  out_halt,
    output logic                  err
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_req, r_we;
    logic [DATA_W-1:0]     r_addr, r_wdata;
    logic                  r_p_regwrite, r_p_memtoreg;
    logic [REG_ADDR_W-1:0] r_p_writereg;
    logic                  r_out_valid, r_out_regwrite, r_out_memtoreg, r_out_halt, r_err;
    logic [DATA_W-1:0]     r_out_rdata, r_out_alu;
    logic [REG_ADDR_W-1:0] r_out_writereg;

    logic                  w_accept, w_mem_op, w_misalign, w_start, w_cnt_en, w_expired;
    logic                  w_retire, w_ret_regwrite, w_ret_memtoreg, w_ret_halt, w_set_err;
    logic [DATA_W-1:0]     w_ret_alu, w_ret_rdata;
    logic [REG_ADDR_W-1:0] w_ret_writereg;

    assign in_ready     = (r_state == IDLE);
    assign w_accept     = in_valid & in_ready;
    assign w_mem_op     = in_memRead | in_memWrite;
    assign w_misalign   = is_unaligned(w_mem_op, in_aluOut[0]);
    assign w_cnt_en     = (r_state == REQ) || (r_state == RESP);

    assign mem_req      = r_req;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign out_valid    = r_out_valid;
    assign out_readData = r_out_rdata;
    assign out_aluOut   = r_out_alu;
    assign out_regWrite = r_out_regwrite;
    assign out_writeReg = r_out_writereg;
    assign out_memToReg = r_out_memtoreg;
    assign out_halt     = r_out_halt;
    assign err          = r_err;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // Next state and retirement fields; completions retire the pending fields latched at acceptance.
    always_comb begin
        w_next_state   = r_state;
        w_start        = 1'b0;
        w_retire       = 1'b0;
        w_set_err      = 1'b0;
        w_ret_halt     = 1'b0;
        w_ret_rdata    = {DATA_W{1'b0}};
        w_ret_alu      = r_addr;
        w_ret_regwrite = r_p_regwrite;
        w_ret_writereg = r_p_writereg;
        w_ret_memtoreg = r_p_memtoreg;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ret_alu      = in_aluOut;
                    w_ret_regwrite = in_regWrite;
                    w_ret_writereg = in_writeReg;
                    w_ret_memtoreg = in_memToReg;
                    if (in_halt) begin
                        w_retire     = 1'b1;
                        w_ret_halt   = 1'b1;
                        w_next_state = HALTED;
                    end else if (w_misalign) begin
                        w_retire       = 1'b1;
                        w_ret_regwrite = 1'b0;
                        w_set_err      = 1'b1;
                        w_next_state   = HALTED;
                    end else if (w_mem_op) begin
                        w_start      = 1'b1;
                        w_next_state = REQ;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (r_we) begin
                        w_retire     = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = RESP;
                    end
                end else if (w_expired) begin
                    w_retire       = 1'b1;
                    w_ret_regwrite = 1'b0;
                    w_set_err      = 1'b1;
                    w_next_state   = HALTED;
                end else begin
                    w_next_state = REQ;
                end
            end
            RESP: begin
                // rvalid alongside gnt was seen in REQ and is deliberately not looked at there.
                if (mem_rvalid) begin
                    w_retire     = 1'b1;
                    w_ret_rdata  = mem_rdata;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_retire       = 1'b1;
                    w_ret_regwrite = 1'b0;
                    w_set_err      = 1'b1;
                    w_next_state   = HALTED;
                end else begin
                    w_next_state = RESP;
                end
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = IDLE;
        endcase
    end

    // State, request fields and pending writeback controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= {DATA_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_p_regwrite <= 1'b0;
            r_p_writereg <= {REG_ADDR_W{1'b0}};
            r_p_memtoreg <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_req        <= 1'b1;
                r_we         <= in_memWrite;
                r_addr       <= in_aluOut;
                r_wdata      <= in_writeData;
                r_p_regwrite <= in_regWrite;
                r_p_writereg <= in_writeReg;
                r_p_memtoreg <= in_memToReg;
            end else if ((r_state == REQ) && (mem_gnt || w_expired)) begin
                r_req <= 1'b0;
            end else begin
                r_req <= r_req;
            end
        end
    end

    // Result registers: one-cycle valid pulse, everything else holds between retirements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid    <= 1'b0;
            r_out_rdata    <= {DATA_W{1'b0}};
            r_out_alu      <= {DATA_W{1'b0}};
            r_out_regwrite <= 1'b0;
            r_out_writereg <= {REG_ADDR_W{1'b0}};
            r_out_memtoreg <= 1'b0;
            r_out_halt     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_out_valid <= w_retire;
            r_err       <= r_err | w_set_err;
            if (w_retire) begin
                r_out_rdata    <= w_ret_rdata;
                r_out_alu      <= w_ret_alu;
                r_out_regwrite <= w_ret_regwrite;
                r_out_writereg <= w_ret_writereg;
                r_out_memtoreg <= w_ret_memtoreg;
                r_out_halt     <= w_ret_halt;
            end else begin
                r_out_rdata    <= r_out_rdata;
                r_out_alu      <= r_out_alu;
                r_out_regwrite <= r_out_regwrite;
                r_out_writereg <= r_out_writereg;
                r_out_memtoreg <= r_out_memtoreg;
                r_out_halt     <= r_out_halt;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a default instance plus a TIMEOUT=4 instance on shared stimulus.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_memRead, in_memWrite, in_halt, in_regWrite, in_memToReg;
    logic [15:0] in_aluOut, in_writeData;
    logic [2:0]  in_writeReg;
    logic        mem_gnt, mem_rvalid;
    logic [15:0] mem_rdata;

    logic        in_ready, mem_req, mem_we, out_valid, out_regWrite, out_memToReg, out_halt, err;
    logic [15:0] mem_addr, mem_wdata, out_readData, out_aluOut;
    logic [2:0]  out_writeReg;

    logic        t_in_ready, t_mem_req, t_mem_we, t_out_valid, t_out_regWrite, t_out_memToReg, t_out_halt, t_err;
    logic [15:0] t_mem_addr, t_mem_wdata, t_out_readData, t_out_aluOut;
    logic [2:0]  t_out_writeReg;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluOut(in_aluOut), .in_writeData(in_writeData), .in_memRead(in_memRead),
        .in_memWrite(in_memWrite), .in_halt(in_halt), .in_regWrite(in_regWrite),
        .in_writeReg(in_writeReg), .in_memToReg(in_memToReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_readData(out_readData), .out_aluOut(out_aluOut),
        .out_regWrite(out_regWrite), .out_writeReg(out_writeReg), .out_memToReg(out_memToReg),
        .out_halt(out_halt), .err(err)
    );

    mem_stage #(.TIMEOUT(4), .CNT_W(3)) dut_to (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_aluOut(in_aluOut), .in_writeData(in_writeData), .in_memRead(in_memRead),
        .in_memWrite(in_memWrite), .in_halt(in_halt), .in_regWrite(in_regWrite),
        .in_writeReg(in_writeReg), .in_memToReg(in_memToReg),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(t_out_valid), .out_readData(t_out_readData), .out_aluOut(t_out_aluOut),
        .out_regWrite(t_out_regWrite), .out_writeReg(t_out_writeReg), .out_memToReg(t_out_memToReg),
        .out_halt(t_out_halt), .err(t_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] alu;
        logic        rw;
        logic [2:0]  wr;
        logic        m2r;
        logic        e_valid;
        logic [15:0] e_alu;
        logic        e_rw;
        logic [2:0]  e_wr;
        logic        e_m2r;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_aluOut = 16'h0; in_writeData = 16'h0; in_memRead = 1'b0;
        in_memWrite = 1'b0; in_halt = 1'b0; in_regWrite = 1'b0; in_writeReg = 3'd0;
        in_memToReg = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic op(input logic [15:0] alu, input logic rd, input logic wr_en, input logic hlt,
                      input logic rw, input logic [2:0] wreg, input logic [15:0] wdata);
        in_valid = 1'b1; in_aluOut = alu; in_memRead = rd; in_memWrite = wr_en; in_halt = hlt;
        in_regWrite = rw; in_writeReg = wreg; in_memToReg = rd; in_writeData = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b1, 3'd5, 1'b0, 1'b1, 16'h1234, 1'b1, 3'd5, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 1'b0, 3'd7, 1'b1, 1'b1, 16'hFFFF, 1'b0, 3'd7, 1'b1};
        vecs[2] = '{1'b0, 16'h5555, 1'b1, 3'd2, 1'b0, 1'b0, 16'hFFFF, 1'b0, 3'd7, 1'b1};
        vecs[3] = '{1'b1, 16'h0001, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0001, 1'b1, 3'd0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 1'b1, 3'd3, 1'b1, 1'b1, 16'h8000, 1'b1, 3'd3, 1'b1};

        idle_in();
        #3;
        chk("rst out_valid", {15'd0, out_valid}, 16'h0);
        chk("rst mem_req", {15'd0, mem_req}, 16'h0);
        chk("rst outs", {out_aluOut | out_readData | mem_addr | mem_wdata}, 16'h0);
        chk("rst flags", {10'd0, mem_we, out_regWrite, out_memToReg, out_halt, err, out_writeReg != 3'd0}, 16'h0);
        chk("rst t outs", {t_out_aluOut | t_out_readData | t_mem_addr | t_mem_wdata}, 16'h0);
        chk("rst t flags", {8'd0, t_mem_req, t_mem_we, t_out_valid, t_out_regWrite, t_out_memToReg,
                            t_out_halt, t_err, t_out_writeReg != 3'd0}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("idle in_ready", {15'd0, in_ready}, 16'h1);

        // Back-to-back non-memory ops and a bubble.
        for (int i = 0; i < 5; i++) begin
            in_valid = vecs[i].valid; in_aluOut = vecs[i].alu; in_regWrite = vecs[i].rw;
            in_writeReg = vecs[i].wr; in_memToReg = vecs[i].m2r;
            tick();
            chk($sformatf("v%0d out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].e_valid});
            chk($sformatf("v%0d out_aluOut", i), out_aluOut, vecs[i].e_alu);
            chk($sformatf("v%0d wb", i), {11'd0, out_regWrite, out_writeReg, out_memToReg},
                {11'd0, vecs[i].e_rw, vecs[i].e_wr, vecs[i].e_m2r});
            chk($sformatf("v%0d readData", i), out_readData, 16'h0);
            chk($sformatf("v%0d in_ready", i), {15'd0, in_ready}, 16'h1);
        end
        idle_in();

        // Load: gnt at T+3 (with a stray rvalid), rvalid at T+5.
        op(16'h0040, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0);
        tick();                                    // T+1
        idle_in();
        chk("ld T1 req", {14'd0, mem_req, mem_we}, 16'h2);
        chk("ld T1 addr", mem_addr, 16'h0040);
        chk("ld T1 ready", {15'd0, in_ready}, 16'h0);
        tick();                                    // T+2
        chk("ld T2 req", {15'd0, mem_req}, 16'h1);
        tick();                                    // T+3
        chk("ld T3 req", {15'd0, mem_req}, 16'h1);
        chk("ld T3 addr", mem_addr, 16'h0040);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();                                    // T+4
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("ld T4 req/valid/ready", {13'd0, mem_req, out_valid, in_ready}, 16'h0);
        tick();                                    // T+5
        chk("ld T5 ready", {14'd0, out_valid, in_ready}, 16'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        tick();                                    // T+6
        mem_rvalid = 1'b0;
        chk("ld T6 valid/ready", {14'd0, out_valid, in_ready}, 16'h3);
        chk("ld T6 readData", out_readData, 16'hBEEF);
        chk("ld T6 aluOut", out_aluOut, 16'h0040);
        chk("ld T6 wb", {11'd0, out_regWrite, out_writeReg, out_memToReg}, {11'd0, 1'b1, 3'd2, 1'b1});
        tick();
        chk("ld T7 pulse end", {15'd0, out_valid}, 16'h0);
        chk("ld T7 hold", out_readData, 16'hBEEF);

        // Store granted immediately, next op taken at T+2.
        op(16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'hA5A5);
        tick();                                    // T+1
        idle_in();
        mem_gnt = 1'b1;
        chk("st T1 req/we", {14'd0, mem_req, mem_we}, 16'h3);
        chk("st T1 wdata", mem_wdata, 16'hA5A5);
        chk("st T1 addr", mem_addr, 16'h0010);
        tick();                                    // T+2
        mem_gnt = 1'b0;
        chk("st T2 valid/ready/req", {13'd0, out_valid, in_ready, mem_req}, 16'h6);
        chk("st T2 readData", out_readData, 16'h0);
        op(16'h0777, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0);
        tick();                                    // T+3
        idle_in();
        chk("st next op", {15'd0, out_valid}, 16'h1);
        chk("st next aluOut", out_aluOut, 16'h0777);
        chk("st err", {15'd0, err}, 16'h0);

        // Timeout (TIMEOUT=4 instance): no gnt ever.
        do_reset();
        op(16'h0020, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0);
        tick();
        idle_in();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to req c%0d", c), {15'd0, t_mem_req}, 16'h1);
            if (c < 4) tick();
        end
        tick();
        chk("to drop req", {15'd0, t_mem_req}, 16'h0);
        chk("to valid/rw/err/ready", {12'd0, t_out_valid, t_out_regWrite, t_err, t_in_ready}, 16'hA);
        chk("to default still waiting", {14'd0, mem_req, err}, 16'h2);
        tick();
        chk("to halted", {13'd0, t_out_valid, t_in_ready, t_err}, 16'h1);

        // Load completing on the 4th outstanding cycle succeeds.
        do_reset();
        op(16'h0022, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0);
        tick();                                    // cycle 1
        idle_in();
        mem_gnt = 1'b1;
        tick();                                    // cycle 2
        mem_gnt = 1'b0;
        tick();                                    // cycle 3
        tick();                                    // cycle 4
        mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        tick();
        mem_rvalid = 1'b0;
        chk("to-ok valid/err/ready/rw", {12'd0, t_out_valid, t_err, t_in_ready, t_out_regWrite}, 16'hB);
        chk("to-ok readData", t_out_readData, 16'h1357);
        chk("to-ok default readData", out_readData, 16'h1357);

        // Unaligned load: no request, error, halted.
        op(16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0);
        tick();
        op(16'h0999, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0);
        chk("ua req", {15'd0, mem_req}, 16'h0);
        chk("ua valid/rw/err/ready", {12'd0, out_valid, out_regWrite, err, in_ready}, 16'hA);
        tick();
        idle_in();
        chk("ua stall", {13'd0, out_valid, in_ready, mem_req}, 16'h0);
        chk("ua hold aluOut", out_aluOut, 16'h0003);
        chk("ua err sticky", {15'd0, err}, 16'h1);

        // Halt carrying a load: halt only.
        do_reset();
        op(16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        tick();
        idle_in();
        chk("halt T1", {11'd0, out_valid, out_halt, in_ready, mem_req, err}, 16'h18);
        tick();
        chk("halt T2", {13'd0, out_valid, out_halt, mem_req}, 16'h2);

        // Reset during a pending load, then a late rvalid.
        do_reset();
        op(16'h0050, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0);
        tick();
        idle_in();
        chk("rm req before", {15'd0, mem_req}, 16'h1);
        #2 rst = 1'b0;
        #1;
        chk("rm async req/halt/err", {13'd0, mem_req, out_halt, err}, 16'h0);
        chk("rm async addr", mem_addr, 16'h0);
        chk("rm async aluOut", out_aluOut, 16'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("rm late rvalid", {15'd0, out_valid}, 16'h0);
        chk("rm readData", out_readData, 16'h0);
        chk("rm ready", {15'd0, in_ready}, 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
